// File: rtl/uart_fifo_if.sv
// MMIO bus bundle for the FIFO UART.
// The bus master drives the strobes; the peripheral returns registered read data.
interface uart_fifo_if;
  logic [2:0]  device_select;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data_in;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [7:0]  mmio_data_out;

  modport master (
    output device_select, mmio_addr,
    output mmio_data_in, mmio_wr, mmio_rd,
    input  mmio_data_out
  );

  modport slave (
    input  device_select, mmio_addr,
    input  mmio_data_in, mmio_wr, mmio_rd,
    output mmio_data_out
  );
endinterface

// File: rtl/uart_fifo.sv
// MMIO UART with TX/RX FIFOs, programmable frame and sticky errors.
// RX samples mid-bit; all bit timing comes from one shared divider.
module uart_fifo #(
  parameter logic [2:0] DEVICE_ADDRESS = 3'b011,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8
) (
  input  logic clk,
  input  logic rst,
  uart_fifo_if.slave bus,
  input  logic rx,
  output logic tx
);
  localparam int DB  = DATA_BITS;
  localparam int IW  = $clog2(DB);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic sel, wr, rd;
  logic [15:0] addr;
  assign sel  = bus.device_select == DEVICE_ADDRESS;
  assign wr   = sel & bus.mmio_wr;
  assign rd   = sel & bus.mmio_rd;
  assign addr = bus.mmio_addr;

  logic wr_cr, wr_cdh, wr_cdl, wr_do;
  logic rd_sr, rd_di;
  assign wr_cr  = wr && addr == 16'd0;
  assign wr_cdh = wr && addr == 16'd2;
  assign wr_cdl = wr && addr == 16'd3;
  assign wr_do  = wr && addr == 16'd5;
  assign rd_sr  = rd && addr == 16'd1;
  assign rd_di  = rd && addr == 16'd4;

  logic [3:0]  cr_q;
  logic [15:0] cdiv_q;
  logic par_en, par_odd;
  assign par_en  = cr_q[3] ^ cr_q[2];
  assign par_odd = cr_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_q   <= '0;
      cdiv_q <= '0;
    end else begin
      if (wr_cr)  cr_q <= bus.mmio_data_in[3:0];
      if (wr_cdh) cdiv_q[15:8] <= bus.mmio_data_in;
      if (wr_cdl) cdiv_q[7:0]  <= bus.mmio_data_in;
    end
  end

  // TX FIFO
  logic [DB-1:0] tmem [TX_DEPTH];
  logic [TAW:0]  twp, trp;
  logic t_empty, t_full, t_pop, t_push, txovf_set;
  logic [DB-1:0] t_head;
  assign t_empty = twp == trp;
  assign t_full  = (twp[TAW] != trp[TAW]) &&
                   (twp[TAW-1:0] == trp[TAW-1:0]);
  assign t_head  = tmem[trp[TAW-1:0]];
  assign t_push  = wr_do && (!t_full || t_pop);
  assign txovf_set = wr_do && t_full && !t_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      twp <= '0;
      trp <= '0;
    end else begin
      if (t_push) twp <= twp + 1'b1;
      if (t_pop)  trp <= trp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (t_push) tmem[twp[TAW-1:0]] <= bus.mmio_data_in[DB-1:0];
  end

  // RX FIFO
  logic [DB-1:0] rmem [RX_DEPTH];
  logic [RAW:0]  rwp, rrp;
  logic r_empty, r_full, r_pop, r_push, r_push_req, rxovr_set;
  logic [DB-1:0] r_head, rsh_q;
  assign r_empty = rwp == rrp;
  assign r_full  = (rwp[RAW] != rrp[RAW]) &&
                   (rwp[RAW-1:0] == rrp[RAW-1:0]);
  assign r_head  = rmem[rrp[RAW-1:0]];
  assign r_pop   = rd_di && !r_empty;
  assign r_push  = r_push_req && (!r_full || r_pop);
  assign rxovr_set = r_push_req && r_full && !r_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rwp <= '0;
      rrp <= '0;
    end else begin
      if (r_push) rwp <= rwp + 1'b1;
      if (r_pop)  rrp <= rrp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_push) rmem[rwp[RAW-1:0]] <= rsh_q;
  end

  // TX FSM
  state_t ts_q, ts_n;
  logic [15:0] tcnt_q, tcnt_n;
  logic [DB-1:0] tsh_q, tsh_n;
  logic [IW-1:0] tidx_q, tidx_n;
  logic tpar_q, tpar_n, tpen_q, tpen_n;
  logic tx_n, t_start, ttick;
  assign t_start = cr_q[1] && !t_empty;
  assign ttick   = tcnt_q == 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q   <= S_IDLE;
      tcnt_q <= '0;
      tsh_q  <= '0;
      tidx_q <= '0;
      tpar_q <= 1'b0;
      tpen_q <= 1'b0;
      tx     <= 1'b1;
    end else begin
      ts_q   <= ts_n;
      tcnt_q <= tcnt_n;
      tsh_q  <= tsh_n;
      tidx_q <= tidx_n;
      tpar_q <= tpar_n;
      tpen_q <= tpen_n;
      tx     <= tx_n;
    end
  end

  always_comb begin
    ts_n   = ts_q;
    tcnt_n = tcnt_q;
    tsh_n  = tsh_q;
    tidx_n = tidx_q;
    tpar_n = tpar_q;
    tpen_n = tpen_q;
    t_pop  = 1'b0;
    tx_n   = 1'b1;
    if (ts_q != S_IDLE)
      tcnt_n = ttick ? cdiv_q : tcnt_q - 16'd1;
    case (ts_q)
      S_IDLE: if (t_start) begin
        ts_n   = S_START;
        tcnt_n = cdiv_q;
        tsh_n  = t_head;
        tpar_n = ^t_head ^ par_odd;
        tpen_n = par_en;
        t_pop  = 1'b1;
      end
      S_START: if (ttick) begin
        ts_n   = S_DATA;
        tidx_n = '0;
      end
      S_DATA: if (ttick) begin
        tsh_n = tsh_q >> 1;
        if (tidx_q == LAST)
          ts_n = tpen_q ? S_PARITY : S_STOP;
        else
          tidx_n = tidx_q + IW'(1);
      end
      S_PARITY: if (ttick) ts_n = S_STOP;
      S_STOP: if (ttick) begin
        if (t_start) begin
          ts_n   = S_START;
          tsh_n  = t_head;
          tpar_n = ^t_head ^ par_odd;
          tpen_n = par_en;
          t_pop  = 1'b1;
        end else begin
          ts_n = S_IDLE;
        end
      end
      default: ts_n = S_IDLE;
    endcase
    // Line level follows the next state so tx lines up with it
    case (ts_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = tsh_n[0];
      S_PARITY: tx_n = tpar_n;
      default:  tx_n = 1'b1;
    endcase
  end

  // RX synchroniser and FSM
  logic rs1, rs2, rprev, rfall;
  assign rfall = rprev & ~rs2;

  state_t rs_q, rs_n;
  logic [15:0] rcnt_q, rcnt_n;
  logic [DB-1:0] rsh_n;
  logic [IW-1:0] ridx_q, ridx_n;
  logic rperr_q, rperr_n, rtick;
  logic fe_set, pe_set;
  assign rtick = rcnt_q == 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1     <= 1'b1;
      rs2     <= 1'b1;
      rprev   <= 1'b1;
      rs_q    <= S_IDLE;
      rcnt_q  <= '0;
      rsh_q   <= '0;
      ridx_q  <= '0;
      rperr_q <= 1'b0;
    end else begin
      rs1     <= rx;
      rs2     <= rs1;
      rprev   <= rs2;
      rs_q    <= rs_n;
      rcnt_q  <= rcnt_n;
      rsh_q   <= rsh_n;
      ridx_q  <= ridx_n;
      rperr_q <= rperr_n;
    end
  end

  always_comb begin
    rs_n       = rs_q;
    rcnt_n     = rcnt_q;
    rsh_n      = rsh_q;
    ridx_n     = ridx_q;
    rperr_n    = rperr_q;
    r_push_req = 1'b0;
    fe_set     = 1'b0;
    pe_set     = 1'b0;
    if (rs_q != S_IDLE)
      rcnt_n = rtick ? cdiv_q : rcnt_q - 16'd1;
    case (rs_q)
      S_IDLE: if (rfall) begin
        rs_n    = S_START;
        rcnt_n  = cdiv_q >> 1;
        rperr_n = 1'b0;
      end
      S_START: if (rtick) begin
        rs_n   = rs2 ? S_IDLE : S_DATA;
        ridx_n = '0;
      end
      S_DATA: if (rtick) begin
        rsh_n = {rs2, rsh_q[DB-1:1]};
        if (ridx_q == LAST)
          rs_n = par_en ? S_PARITY : S_STOP;
        else
          ridx_n = ridx_q + IW'(1);
      end
      S_PARITY: if (rtick) begin
        rperr_n = rs2 ^ (^rsh_q) ^ par_odd;
        rs_n    = S_STOP;
      end
      S_STOP: if (rtick) begin
        rs_n = S_IDLE;
        if (!rs2) begin
          fe_set = 1'b1;
        end else begin
          r_push_req = 1'b1;
          pe_set     = rperr_q;
        end
      end
      default: rs_n = S_IDLE;
    endcase
    if (!cr_q[0]) begin
      rs_n       = S_IDLE;
      r_push_req = 1'b0;
      fe_set     = 1'b0;
      pe_set     = 1'b0;
    end
  end

  // Sticky flags: a set in the clearing cycle wins
  logic txovf_q, pe_q, fe_q, rxovr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txovf_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      rxovr_q <= 1'b0;
    end else begin
      txovf_q <= txovf_set | (txovf_q & ~rd_sr);
      pe_q    <= pe_set    | (pe_q    & ~rd_sr);
      fe_q    <= fe_set    | (fe_q    & ~rd_sr);
      rxovr_q <= rxovr_set | (rxovr_q & ~rd_sr);
    end
  end

  logic [7:0] sr, di, rdata;
  assign sr = {1'b0, txovf_q, pe_q, fe_q, rxovr_q,
               ts_q != S_IDLE, !t_full, !r_empty};
  assign di = r_empty ? 8'h00 : 8'(r_head);

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      addr == 16'd0: rdata = {4'h0, cr_q};
      addr == 16'd1: rdata = sr;
      addr == 16'd2: rdata = cdiv_q[15:8];
      addr == 16'd3: rdata = cdiv_q[7:0];
      addr == 16'd4: rdata = di;
      default:       rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     bus.mmio_data_out <= 8'h00;
    else if (rd) bus.mmio_data_out <= rdata;
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: reads and tx bits are queued as
// expectations and checked by independent monitor processes.
module tb_uart_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_if bus();
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic tx;
  logic rx_line;
  assign rx_line = loop ? tx : rx_drv;

  uart_fifo #(
    .DEVICE_ADDRESS(3'b011),
    .DATA_BITS(8),
    .TX_DEPTH(8),
    .RX_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .rx(rx_line),
    .tx(tx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [7:0] act,
                       logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h",
               name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;
  exp_t rdq[$];
  logic txq[$];
  int bit_clks = 4;

  // Read-data monitor
  logic rd_seen = 1'b0;
  always @(posedge clk)
    rd_seen <= bus.mmio_rd && bus.device_select == 3'b011;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rdq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got %02h",
                 bus.mmio_data_out);
      end else begin
        exp_t e;
        e = rdq.pop_front();
        check(e.name, bus.mmio_data_out, e.val);
      end
    end
  end

  // Serial line monitor: mid-bit samples after a falling edge
  logic tx_prev = 1'b1;
  logic txm_on  = 1'b0;
  int   txm_cnt = 0;
  always @(negedge clk) begin
    if (txm_cnt > 0) begin
      txm_cnt--;
    end else if (txm_on) begin
      check("tx_bit", {7'h00, tx}, {7'h00, txq.pop_front()});
      if (txq.size() == 0) txm_on = 1'b0;
      else txm_cnt = bit_clks - 1;
    end else if (txq.size() > 0 && tx_prev && !tx) begin
      txm_on  = 1'b1;
      txm_cnt = bit_clks / 2 - 1;
    end
    tx_prev = tx;
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d,
                    logic [2:0] s = 3'b011);
    @(negedge clk);
    bus.device_select = s;
    bus.mmio_addr     = a;
    bus.mmio_data_in  = d;
    bus.mmio_wr       = 1'b1;
    @(negedge clk);
    bus.mmio_wr       = 1'b0;
    bus.device_select = 3'b000;
  endtask

  task automatic rd(logic [15:0] a, logic [7:0] e, string nm);
    exp_t x;
    @(negedge clk);
    x.name = nm;
    x.val  = e;
    rdq.push_back(x);
    bus.device_select = 3'b011;
    bus.mmio_addr     = a;
    bus.mmio_rd       = 1'b1;
    @(negedge clk);
    bus.mmio_rd       = 1'b0;
    bus.device_select = 3'b000;
  endtask

  // 8 clocks per bit, no parity
  task automatic send_frame(logic [7:0] d, logic stop_b);
    rx_drv = 1'b0;
    idle(8);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      idle(8);
    end
    rx_drv = stop_b;
    idle(8);
    rx_drv = 1'b1;
    idle(16);
  endtask

  logic [7:0] rxb [9] = '{8'hA5, 8'h3C, 8'hFF, 8'h00,
                          8'h81, 8'h7E, 8'h12, 8'hC9, 8'h55};
  logic [7:0] b55 = 8'h55;

  initial begin
    bus.device_select = 3'b000;
    bus.mmio_addr     = '0;
    bus.mmio_data_in  = '0;
    bus.mmio_wr       = 1'b0;
    bus.mmio_rd       = 1'b0;
    idle(3);
    check("rst_tx", {7'h00, tx}, 8'h01);
    check("rst_dout", bus.mmio_data_out, 8'h00);
    rst = 1'b0;
    rd(16'd1, 8'h02, "rst_sr");
    rd(16'd0, 8'h00, "rst_cr");

    // 0x55, 4 clocks per bit
    wr(16'd2, 8'h00);
    wr(16'd3, 8'h03);
    wr(16'd0, 8'h02);
    bit_clks = 4;
    txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) txq.push_back(b55[i]);
    txq.push_back(1'b1);
    wr(16'd5, 8'h55);
    idle(10);
    rd(16'd1, 8'h06, "t1_busy_sr");
    idle(40);
    rd(16'd1, 8'h02, "t1_done_sr");
    check("t1_idle_tx", {7'h00, tx}, 8'h01);

    // Loopback, even parity, 8 clocks per bit
    wr(16'd3, 8'h07);
    loop = 1'b1;
    wr(16'd0, 8'h07);
    bit_clks = 8;
    txq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr(16'd5, 8'h07);
    idle(130);
    rd(16'd1, 8'h03, "t2_sr_rxr");
    rd(16'd4, 8'h07, "t2_di");
    rd(16'd1, 8'h02, "t2_sr_after");
    loop = 1'b0;

    // TX overflow with TXE off
    wr(16'd0, 8'h01);
    for (int i = 0; i < 9; i++) wr(16'd5, 8'h10 + 8'(i));
    rd(16'd1, 8'h40, "t3_sr_ovf");
    rd(16'd1, 8'h00, "t3_sr_clr");

    // RX overflow
    for (int i = 0; i < 9; i++) send_frame(rxb[i], 1'b1);
    rd(16'd1, 8'h09, "t4_sr_ovr");
    for (int i = 0; i < 8; i++) rd(16'd4, rxb[i], "t4_di");
    rd(16'd4, 8'h00, "t4_di_empty");
    rd(16'd1, 8'h00, "t4_sr_clr");

    // Framing error and glitch
    send_frame(8'h5A, 1'b0);
    rd(16'd1, 8'h10, "t5_sr_fe");
    @(negedge clk) rx_drv = 1'b0;
    @(negedge clk) rx_drv = 1'b1;
    idle(40);
    rd(16'd1, 8'h00, "t5_sr_glitch");
    rd(16'd4, 8'h00, "t5_di_glitch");

    // Decode and read-only offsets
    wr(16'd0, 8'h0C, 3'b000);
    rd(16'd0, 8'h01, "cr_unselected");
    rd(16'd3, 8'h07, "cdiv_l");
    rd(16'd5, 8'h00, "do_read");
    rd(16'd7, 8'h00, "unmapped");

    // Reset mid-frame: TX FIFO holds 0x10..0x17
    wr(16'd0, 8'h03);
    rd(16'd0, 8'h03, "t6_cr");
    idle(18);
    check("t6_tx_mid", {7'h00, tx}, 8'h00);
    rst = 1'b1;
    #1;
    check("t6_rst_tx", {7'h00, tx}, 8'h01);
    check("t6_rst_dout", bus.mmio_data_out, 8'h00);
    idle(2);
    rst = 1'b0;
    rd(16'd1, 8'h02, "t6_sr");
    wr(16'd0, 8'h02);
    idle(5);
    rd(16'd1, 8'h02, "t6_tx_empty");
    rd(16'd4, 8'h00, "t6_rx_empty");

    idle(10);
    n_tests++;
    if (rdq.size() != 0 || txq.size() != 0) begin
      n_fail++;
      $display("FAIL pending: got %0d/%0d left, expected 0/0",
               rdq.size(), txq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
